// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V register-file widths and index/mask types.
package rv_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [NUM_REGS-1:0]   reg_mask_t;
endpackage

// File: rtl/reg_scoreboard_onehot_decoder.sv
// onehot_decoder: enable-gated binary to one-hot decoder, out = en ? 1<<sl : 0.
module onehot_decoder #(
   parameter int IN_W  = 5,
   parameter int OUT_W = 2**IN_W
) (
   input  logic [IN_W-1:0]  sl,
   input  logic             en,
   output logic [OUT_W-1:0] out
);
   assign out = en ? OUT_W'(1) << sl : '0;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register-busy scoreboard with RAW/WAW and pending-cap stall.
// SCOREBOARD_WB_BYPASS_EN: a register written back this cycle counts as free for issue.
module reg_scoreboard
   import rv_pkg::*;
#(
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int MAX_PEND = 4,
   parameter int CNT_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iss_valid,
   input  logic [ADDR_W-1:0]    iss_rd,
   input  logic                 iss_rd_we,
   input  logic [ADDR_W-1:0]    iss_rs1,
   input  logic [ADDR_W-1:0]    iss_rs2,
   output logic                 iss_ready,
   input  logic                 wb_valid,
   input  logic [ADDR_W-1:0]    wb_rd,
   input  logic                 flush,
   output logic [2**ADDR_W-1:0] busy_vec,
   output logic [CNT_W-1:0]     pend_cnt,
   output logic                 wb_err
);
   localparam int NREGS = 2**ADDR_W;
   logic [NREGS-1:0] busy_q, busy_d, set_mask, clr_mask, haz;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             err_q, err_d, set_en, clr_en, pend_full;
   // busy_q[0] is never set, so a writeback to x0 is never a valid clear
   assign clr_en = wb_valid && busy_q[wb_rd];
`ifdef SCOREBOARD_WB_BYPASS_EN
   assign haz       = busy_q & ~clr_mask;
   assign pend_full = (pend_q == CNT_W'(MAX_PEND)) && !clr_en;
`else
   assign haz       = busy_q;
   assign pend_full = pend_q == CNT_W'(MAX_PEND);
`endif
   assign iss_ready = !(haz[iss_rs1] || haz[iss_rs2] ||
                        (iss_rd_we && (haz[iss_rd] || (iss_rd != '0 && pend_full))));
   assign set_en    = iss_valid && iss_ready && iss_rd_we && iss_rd != '0;
   onehot_decoder #(.IN_W(ADDR_W), .OUT_W(NREGS)) u_set_dec (
      .sl (iss_rd),
      .en (set_en),
      .out(set_mask)
   );
   onehot_decoder #(.IN_W(ADDR_W), .OUT_W(NREGS)) u_clr_dec (
      .sl (wb_rd),
      .en (clr_en),
      .out(clr_mask)
   );
   // set is OR-ed after the clear so a same-register collision keeps the bit
   always_comb begin
      busy_d    = flush ? '0 : (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
      pend_d    = flush ? '0 : pend_q + CNT_W'(set_en) - CNT_W'(clr_en);
      err_d     = err_q || (wb_valid && !busy_q[wb_rd]);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         pend_q <= pend_d;
         err_q  <= err_d;
      end
   end
   assign busy_vec = busy_q;
   assign pend_cnt = pend_q;
   assign wb_err   = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: table-driven vectors plus hand sequences for bypass, cap and async reset.
module tb_reg_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic        clk = 1'b0, rst = 1'b1;
   logic        iss_valid = 0, iss_rd_we = 0, wb_valid = 0, flush = 0, iss_ready, wb_err;
   logic [4:0]  iss_rd = 0, iss_rs1 = 0, iss_rs2 = 0, wb_rd = 0;
   logic [31:0] busy_vec;
   logic [2:0]  pend_cnt;
   int          n_cmp = 0, n_bad = 0;

   typedef struct {
      logic iv; logic [4:0] rd; logic we; logic [4:0] rs1; logic [4:0] rs2;
      logic wv; logic [4:0] wrd; logic fl;
      logic rdy; logic [31:0] busy; logic [2:0] cnt; logic err;
   } vec_t;
   vec_t tbl[$];

   reg_scoreboard #(.ADDR_W(5), .MAX_PEND(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_rd_we(iss_rd_we),
      .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_ready(iss_ready), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .flush(flush), .busy_vec(busy_vec), .pend_cnt(pend_cnt), .wb_err(wb_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic iv, input int rd, input logic we, input int rs1,
                               input int rs2, input logic wv, input int wrd, input logic fl,
                               input logic rdy, input logic [31:0] busy, input int cnt,
                               input logic err);
      vec_t v;
      v.iv = iv; v.rd = 5'(rd); v.we = we; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
      v.wv = wv; v.wrd = 5'(wrd); v.fl = fl;
      v.rdy = rdy; v.busy = busy; v.cnt = 3'(cnt); v.err = err;
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   task automatic drive(input vec_t v);
      iss_valid = v.iv; iss_rd = v.rd; iss_rd_we = v.we; iss_rs1 = v.rs1; iss_rs2 = v.rs2;
      wb_valid = v.wv; wb_rd = v.wrd; flush = v.fl;
   endtask

   // called at a negedge; checks ready mid-cycle and state just after the edge
   task automatic run(input vec_t v, input string tag);
      drive(v);
      #1 chk({tag, ".ready"}, 32'(iss_ready), 32'(v.rdy));
      @(posedge clk);
      #1;
      chk({tag, ".busy"}, busy_vec, v.busy);
      chk({tag, ".cnt"}, 32'(pend_cnt), 32'(v.cnt));
      chk({tag, ".err"}, 32'(wb_err), 32'(v.err));
      @(negedge clk);
   endtask

   initial begin
      tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1, 32'h0,   0,0));
      tbl.push_back(mk(1,5,1,0,0, 0,0,0, 1, 32'h20,  1,0));
      tbl.push_back(mk(0,0,0,0,0, 1,5,0, 1, 32'h0,   0,0));
      tbl.push_back(mk(1,5,1,0,0, 0,0,0, 1, 32'h20,  1,0));
      tbl.push_back(mk(1,6,1,5,0, 0,0,0, 0, 32'h20,  1,0));
      tbl.push_back(mk(1,0,0,0,5, 0,0,0, 0, 32'h20,  1,0));
      tbl.push_back(mk(1,5,1,0,0, 0,0,0, 0, 32'h20,  1,0));
      tbl.push_back(mk(1,0,0,1,2, 0,0,0, 1, 32'h20,  1,0));
      tbl.push_back(mk(1,6,1,0,0, 1,5,0, 1, 32'h40,  1,0));
      tbl.push_back(mk(0,0,0,0,0, 1,6,0, 1, 32'h0,   0,0));
      tbl.push_back(mk(1,1,1,0,0, 0,0,0, 1, 32'h2,   1,0));
      tbl.push_back(mk(1,2,1,0,0, 0,0,0, 1, 32'h6,   2,0));
      tbl.push_back(mk(1,3,1,0,0, 0,0,0, 1, 32'hE,   3,0));
      tbl.push_back(mk(1,4,1,0,0, 0,0,0, 1, 32'h1E,  4,0));
      tbl.push_back(mk(1,6,1,0,0, 0,0,0, 0, 32'h1E,  4,0));
      tbl.push_back(mk(1,0,1,0,0, 0,0,0, 1, 32'h1E,  4,0));
      tbl.push_back(mk(1,6,0,0,0, 0,0,0, 1, 32'h1E,  4,0));
      tbl.push_back(mk(1,7,1,0,0, 0,0,1, 0, 32'h0,   0,0));
      tbl.push_back(mk(1,1,1,0,0, 0,0,0, 1, 32'h2,   1,0));
      tbl.push_back(mk(1,2,1,0,0, 0,0,0, 1, 32'h6,   2,0));
      tbl.push_back(mk(1,7,1,0,0, 0,0,1, 1, 32'h0,   0,0));
      tbl.push_back(mk(0,0,0,0,0, 1,3,0, 1, 32'h0,   0,1));
      tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1, 32'h0,   0,1));

      @(posedge clk);
      #1;
      chk("reset.busy", busy_vec, 32'h0);
      chk("reset.cnt", 32'(pend_cnt), 32'h0);
      chk("reset.err", 32'(wb_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

      run(mk(1,5,1,0,0, 0,0,0, 1, 32'h20, 1,1), "ar.setup");
      #2 rst = 1'b1;
      #1;
      chk("ar.busy_now", busy_vec, 32'h0);
      chk("ar.cnt_now", 32'(pend_cnt), 32'h0);
      chk("ar.err_now", 32'(wb_err), 32'h0);
      drive(mk(1,9,1,0,0, 0,0,0, 0, 0, 0,0));
      @(posedge clk);
      #1 chk("ar.busy_held", busy_vec, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      run(mk(0,0,0,0,0, 1,0,0, 1, 32'h0, 0,1), "x0.wb");
      run(mk(1,3,1,0,0, 0,0,1, 1, 32'h0, 0,1), "x0.flush");

      run(mk(1,5,1,0,0, 0,0,0, 1, 32'h20, 1,1), "raw.set");
      run(mk(1,8,1,5,0, 1,5,0, BYP, BYP ? 32'h100 : 32'h0, BYP ? 1 : 0, 1), "raw.byp");
      run(mk(1,0,0,5,0, 0,0,0, 1, BYP ? 32'h100 : 32'h0, BYP ? 1 : 0, 1), "raw.next");
      run(mk(0,0,0,0,0, 0,0,1, 1, 32'h0, 0,1), "raw.flush");

      run(mk(1,5,1,0,0, 0,0,0, 1, 32'h20, 1,1), "same.set");
      run(mk(1,5,1,0,0, 1,5,0, BYP, BYP ? 32'h20 : 32'h0, BYP ? 1 : 0, 1), "same.hit");
      run(mk(0,0,0,0,0, 0,0,1, 1, 32'h0, 0,1), "same.flush");

      for (int r = 1; r <= 4; r++)
         run(mk(1,r,1,0,0, 0,0,0, 1, (32'h1 << (r + 1)) - 32'h2, r,1), $sformatf("cap.rd%0d", r));
      run(mk(1,6,1,0,0, 1,1,0, BYP, BYP ? 32'h5C : 32'h1C, BYP ? 4 : 3, 1), "cap.byp");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end
endmodule
